mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter_id_fifo.sv | 72 +++++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-source memory arbiter.
// Sources are identified by arb_src_e; the ID FIFO stores this 1-bit value.
package mem_arbiter_pkg;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } arb_src_e;

    localparam int MEM_ARB_OUTST_DEPTH = 4;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_id_fifo.sv
// In-order FIFO of source IDs for requests still awaiting a memory response.
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   push_id_i,
    input  logic                   pop_i,
    output logic                   head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        push_ok_s = push_i && !full_o;
        pop_ok_s  = pop_i && !empty_o;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : arb_id_fifo

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one in-order memory port.
// Define MEM_ARB_LSU_PRIO_EN to give the LSU fixed priority on unlocked ties (default: round-robin).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int OUTST_DEPTH = MEM_ARB_OUTST_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          if_req_valid,
    output logic                          if_req_ready,
    input  logic [31:0]                   if_req_addr,
    output logic                          if_resp_valid,
    input  logic                          if_resp_ready,
    output logic [31:0]                   if_resp_data,
    input  logic                          ls_req_valid,
    output logic                          ls_req_ready,
    input  logic [31:0]                   ls_req_addr,
    input  logic                          ls_req_we,
    input  logic [31:0]                   ls_req_wdata,
    input  logic [3:0]                    ls_req_wstrb,
    output logic                          ls_resp_valid,
    input  logic                          ls_resp_ready,
    output logic [31:0]                   ls_resp_data,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [31:0]                   mem_req_addr,
    output logic                          mem_req_we,
    output logic [31:0]                   mem_req_wdata,
    output logic [3:0]                    mem_req_wstrb,
    input  logic                          mem_resp_valid,
    output logic                          mem_resp_ready,
    input  logic [31:0]                   mem_resp_data,
    output logic [$clog2(OUTST_DEPTH):0]  outst_cnt
);

    arb_src_e last_grant_q, last_grant_d;
    arb_src_e lock_src_q, lock_src_d;
    logic     lock_q, lock_d;
    arb_src_e grant_s, tie_src_s, head_src_s;
    logic     src_valid_s, can_issue_s, fire_s;
    logic     fifo_head_s, fifo_full_s, fifo_empty_s, resp_fire_s;

`ifdef MEM_ARB_LSU_PRIO_EN
    assign tie_src_s = SRC_LS;
`else
    assign tie_src_s = (last_grant_q == SRC_LS) ? SRC_IF : SRC_LS;
`endif

    // Grant selection: a stalled request keeps its source until accepted
    always_comb begin
        grant_s = SRC_IF;
        if (lock_q) begin
            grant_s = lock_src_q;
        end else if (if_req_valid && ls_req_valid) begin
            grant_s = tie_src_s;
        end else if (ls_req_valid) begin
            grant_s = SRC_LS;
        end else begin
            grant_s = SRC_IF;
        end
    end

    // Request mux toward memory; fetches are always reads with no strobes
    always_comb begin
        mem_req_addr  = if_req_addr;
        mem_req_we    = 1'b0;
        mem_req_wdata = 32'h0000_0000;
        mem_req_wstrb = 4'b0000;
        src_valid_s   = if_req_valid;
        case (grant_s)
            SRC_LS: begin
                mem_req_addr  = ls_req_addr;
                mem_req_we    = ls_req_we;
                mem_req_wdata = ls_req_wdata;
                mem_req_wstrb = ls_req_wstrb;
                src_valid_s   = ls_req_valid;
            end
            default: begin
                mem_req_addr = if_req_addr;
                src_valid_s  = if_req_valid;
            end
        endcase
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early
    assign can_issue_s   = !rst && !fifo_full_s;
    assign mem_req_valid = can_issue_s && src_valid_s;
    assign if_req_ready  = can_issue_s && mem_req_ready && (grant_s == SRC_IF);
    assign ls_req_ready  = can_issue_s && mem_req_ready && (grant_s == SRC_LS);
    assign fire_s        = mem_req_valid && mem_req_ready;

    assign head_src_s     = arb_src_e'(fifo_head_s);
    assign mem_resp_ready = !rst && !fifo_empty_s &&
                            ((head_src_s == SRC_LS) ? ls_resp_ready : if_resp_ready);
    assign if_resp_valid  = !rst && !fifo_empty_s && (head_src_s == SRC_IF) && mem_resp_valid;
    assign ls_resp_valid  = !rst && !fifo_empty_s && (head_src_s == SRC_LS) && mem_resp_valid;
    assign if_resp_data   = mem_resp_data;
    assign ls_resp_data   = mem_resp_data;
    assign resp_fire_s    = mem_resp_valid && mem_resp_ready;

    // Lock and round-robin history next-state
    always_comb begin
        lock_d       = lock_q;
        lock_src_d   = lock_src_q;
        last_grant_d = last_grant_q;
        if (fire_s) begin
            lock_d       = 1'b0;
            last_grant_d = grant_s;
        end else if (mem_req_valid) begin
            lock_d     = 1'b1;
            lock_src_d = grant_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_src_q   <= SRC_IF;
            last_grant_q <= SRC_LS;
        end else begin
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (fire_s),
        .push_id_i (grant_s),
        .pop_i     (resp_fire_s),
        .head_o    (fifo_head_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .count_o   (outst_cnt)
    );

endmodule : mem_arbiter
